// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ack instruction memory and drives the IF/ID register.
// Optional IF_STALL_COUNTER_EN adds a saturating stall_cycles counter output.
module instruction_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc
`ifdef IF_STALL_COUNTER_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    // Handshake: while imem_req=1 the address is stable until a cycle with imem_ack=1,
    // which completes the fetch; imem_ack is ignored whenever imem_req=0.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [31:0]       hold_q, hold_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_aligned;

    // PC is kept word-aligned, so the low bits of a redirect target are dropped on load.
    assign pc_plus4       = pc_q + ADDR_W'(4);
    assign branch_aligned = branch_address & ~ADDR_W'(3);

    assign imem_req   = !rst && (state_q != ST_HOLD);
    assign imem_addr  = pc_q & ~ADDR_W'(3);
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = redirect_q;
        hold_d       = hold_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;

        case (state_q)
            ST_REQ: begin
                if (branch_taken) begin
                    ifid_valid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = branch_aligned;
                    end else begin
                        redirect_d = branch_aligned;
                        state_d    = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    if (freeze) begin
                        hold_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end
                end else if (!freeze) begin
                    ifid_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d         = branch_aligned;
                    ifid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end else if (!freeze) begin
                    ifid_instr_d = hold_q;
                    ifid_pc_d    = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    state_d      = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The abandoned fetch must still complete before the redirect is issued.
                ifid_valid_d = 1'b0;
                if (imem_ack) begin
                    pc_d    = branch_taken ? branch_aligned : redirect_q;
                    state_d = ST_REQ;
                end else if (branch_taken) begin
                    redirect_d = branch_aligned;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            redirect_q   <= '0;
            hold_q       <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            hold_q       <= hold_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

`ifdef IF_STALL_COUNTER_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_event;

    // A cycle stalls whenever no new instruction can be delivered into IF/ID.
    always_comb begin
        stall_event = ((state_q == ST_REQ) && !imem_ack) ||
                      (state_q == ST_HOLD) || (state_q == ST_DRAIN);
        stall_d     = stall_q;
        if (stall_event && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed scenarios plus random traffic against a queue-based model.
// Build with IF_STALL_COUNTER_EN defined to also cover the stall counter.
module tb_instruction_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
`ifdef IF_STALL_COUNTER_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    instruction_fetch_stage #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc)
`ifdef IF_STALL_COUNTER_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: architectural PC, IF/ID contents, a buffered instruction
    // waiting out a freeze, and a pending redirect waiting for the old fetch to finish.
    logic [31:0] m_pc = RST_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_ifpc = '0;
    logic [31:0] m_hold[$];
    logic [31:0] m_redir[$];
    logic [31:0] m_stall = '0;
    logic        m_rst_cur = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = !m_rst_cur && (m_hold.size() == 0);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_ifpc);
`ifdef IF_STALL_COUNTER_EN
        chk("stall_cycles", stall_cycles, m_stall);
`endif
    endtask

    task automatic bump_stall();
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    endtask

    task automatic model_step(input logic r, input logic br, input logic [31:0] ba,
                              input logic fz, input logic ack, input logic [31:0] rd);
        logic [31:0] ba_al;
        ba_al = ba & ~32'h3;
        if (r) begin
            m_pc = RST_PC; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
            m_hold.delete(); m_redir.delete(); m_stall = '0;
        end else if (m_redir.size() != 0) begin
            bump_stall();
            m_valid = 1'b0;
            if (ack) begin
                m_pc = br ? ba_al : m_redir[0];
                m_redir.delete();
            end else if (br) begin
                m_redir[0] = ba_al;
            end
        end else if (m_hold.size() != 0) begin
            bump_stall();
            if (br) begin
                m_hold.delete(); m_pc = ba_al; m_valid = 1'b0;
            end else if (!fz) begin
                m_instr = m_hold.pop_front();
                m_pc = m_pc + 32'd4; m_ifpc = m_pc; m_valid = 1'b1;
            end
        end else begin
            if (!ack) bump_stall();
            if (br) begin
                m_valid = 1'b0;
                if (ack) m_pc = ba_al;
                else m_redir.push_back(ba_al);
            end else if (ack && fz) begin
                m_hold.push_back(rd);
            end else if (ack) begin
                m_instr = rd; m_pc = m_pc + 32'd4; m_ifpc = m_pc; m_valid = 1'b1;
            end else if (!fz) begin
                m_valid = 1'b0;
            end
        end
        m_rst_cur = r;
    endtask

    // One clock: check outputs on the falling edge, then apply inputs for the next rising edge.
    task automatic step(input logic r, input logic br, input logic [31:0] ba,
                        input logic fz, input logic ack);
        logic [31:0] rd;
        @(negedge clk);
        if (armed) check_all();
        rd = mem_word(m_pc);
        rst = r; branch_taken = br; branch_address = ba; freeze = fz;
        imem_ack = ack; imem_rdata = rd;
        model_step(r, br, ba, fz, ack, rd);
        if (r) armed = 1'b1;
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then four zero-wait fetches.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 1);
        peek();
        chk("seq_ifid_pc_16", ifid_pc, 32'h10);
        chk("seq_addr_16", imem_addr, 32'h10);

        // Two-wait fetch at 0x8.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        peek();
        chk("wait_instr", ifid_instr, mem_word(32'h8));
        chk("wait_pc", ifid_pc, 32'hC);

        // Freeze for three cycles around the ack at 0x10.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        peek();
        chk("hold_ifid_pc", ifid_pc, 32'h14);
        chk("hold_next_addr", imem_addr, 32'h14);

        // Branch during an outstanding request at 0x20, then a second branch during drain.
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 1, 32'h200, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        peek();
        chk("drain_addr_200", imem_addr, 32'h200);
        chk("drain_valid", 32'(ifid_valid), 32'h0);
        step(0, 1, 32'h250, 0, 0);
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 0, 0, 1);
        peek();
        chk("drain_addr_300", imem_addr, 32'h300);

        // Branch beats freeze, low address bits dropped; then PC wrap.
        step(0, 1, 32'h103, 1, 1);
        peek();
        chk("flush_addr_100", imem_addr, 32'h100);
        chk("flush_valid", 32'(ifid_valid), 32'h0);
        step(0, 1, 32'hFFFF_FFFC, 0, 1);
        step(0, 0, 0, 0, 1);
        peek();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_ifid_pc", ifid_pc, 32'h0);

        // Stall accounting: two-wait fetch plus a three-cycle hold.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
`ifdef IF_STALL_COUNTER_EN
        peek();
        chk("stall_5", stall_cycles, 32'd5);
`endif

        // Reset while a request is outstanding, with a late ack during reset.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, br, fz, ack;
            logic [31:0] ba;
            r   = ($urandom_range(0, 63) == 0);
            br  = ($urandom_range(0, 7) == 0);
            fz  = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 1) == 1);
            ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(r, br, ba, fz, ack);
        end
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage ARM pipeline.
- Owns the PC register and fetches 32-bit instructions over a req/ack instruction-memory interface.
- Drives the IF/ID pipeline register.
- Accepts redirects from the branch-target path: branch_address is computed as branch PC+4 + (sign-extended imm24 << 2) + 4, with branch_taken from EXE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- freeze  input  1  hazard stall from hazard unit; hold PC and IF/ID.
- branch_taken  input  1  redirect request from EXE; flushes IF/ID.
- branch_address  input  ADDR_W  redirect target.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_W  fetch address; word-aligned.
- imem_ack  input  1  rdata valid this cycle; meaningful only while imem_req=1.
- imem_rdata  input  32  fetched instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc  output  ADDR_W  fetch address + 4, consumed by the branch-target path as its PC.

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc=RESET_PC, state=REQ.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0.
  - Hold buffer and redirect register cleared.
  - imem_req=0 while rst is high.
  - Reset mid-transaction abandons the outstanding request; a late ack is ignored.
- imem_addr = {pc[ADDR_W-1:2],2'b00} in REQ. In DRAIN it is the held address. branch_address[1:0] is ignored.
- Handshake:
  - imem_req is high in REQ and DRAIN, low in HOLD.
  - While imem_req=1 and imem_ack=0, imem_addr stays stable.
  - Ack may arrive the same cycle as req (0-wait) or any later cycle.
- State REQ:
  - branch_taken=1 with ack: data dropped, pc<=branch_address, ifid_valid<=0, stay REQ.
  - branch_taken=1 without ack: redirect<=branch_address, ifid_valid<=0, go DRAIN; pc unchanged.
  - ack, freeze=0: ifid_instr<=imem_rdata, ifid_pc<=pc+4, ifid_valid<=1, pc<=pc+4, stay REQ. Back-to-back fetches give 1 instruction/cycle with 0-wait memory.
  - ack, freeze=1: hold buffer<=imem_rdata, IF/ID unchanged, go HOLD.
  - no ack, freeze=0: ifid_valid<=0 (bubble).
  - no ack, freeze=1: IF/ID unchanged.
- State HOLD:
  - branch_taken=1: buffer discarded, pc<=branch_address, ifid_valid<=0, go REQ.
  - freeze=1: hold everything.
  - freeze=0: IF/ID<=buffer, pc+4, valid=1; pc<=pc+4; go REQ.
- State DRAIN:
  - branch_taken=1 again: redirect<=branch_address (latest wins).
  - ack: data dropped, pc<=redirect (or the new branch_address if taken the same cycle), go REQ.
  - ifid_valid stays 0 throughout.
- Priority: rst > branch_taken > freeze.
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0). No fault is raised.

Optional Feature:
- Macro: IF_STALL_COUNTER_EN.
- Defined:
  - Adds output stall_cycles[31:0], reset to 0.
  - Increments every cycle where rst=0 and the stage could not deliver a new valid instruction to IF/ID: REQ without ack, HOLD, or DRAIN.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0, 0-wait memory returning addr-based words for 4 cycles -> imem_addr 0,4,8,12; ifid_pc 4,8,12,16; ifid_valid=1 from cycle 2.
- 2-wait memory (ack on 3rd req cycle) -> imem_addr held at 0x8 for 3 cycles, ifid_valid=0 for 2 cycles, then ifid_instr=mem[0x8], ifid_pc=0xC.
- Ack at pc=0x10 with freeze=1 for 3 cycles -> imem_req=0 during HOLD, IF/ID unchanged; on release ifid_pc=0x14, next imem_addr=0x14.
- branch_taken with branch_address=0x200 during an outstanding 2-wait request at 0x20 -> DRAIN, ack data dropped, ifid_valid=0, next imem_addr=0x200. Second branch_taken (0x300) during DRAIN -> next fetch 0x300.
- branch_taken=1 and freeze=1 same cycle with branch_address=0x103 -> flush, next imem_addr=0x100; wrap check: pc=0xFFFF_FFFC then next fetch 0x0.
- With IF_STALL_COUNTER_EN: 2-wait fetch plus 3-cycle HOLD -> stall_cycles=5; without the macro, elaboration has no stall_cycles port.
